// File: rtl/mem_responder_if.sv
// mem_responder_if: cache-port request/response bundle.
// master drives strobes/address/data; slave returns resp, rdata, proto_err.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        proto_err;

  modport master (
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    output mem_address,
    output mem_wdata,
    input  mem_resp,
    input  mem_rdata,
    input  proto_err
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    input  mem_address,
    input  mem_wdata,
    output mem_resp,
    output mem_rdata,
    output proto_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word scratchpad answering one cache-port request at a time
// after LATENCY cycles. Ports: clk, rst (sync, active-high), bus (slave).
// bus carries mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata in,
// mem_resp/mem_rdata/proto_err out. Optional checker: MEM_PROTO_CHECK_EN.
module mem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [31:0] HI_MASK =
    ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        op_wr;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        resp_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH];

  logic                  req;
  logic [31:0]           la;
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  hit;
  logic [31:0]           rd_word;
  logic                  unused;

  assign req = bus.mem_read | bus.mem_write;

  // In IDLE the lookup uses the live address so LATENCY=1 can read
  // on the accept edge; otherwise it uses the latched one.
  assign la      = (state == IDLE) ? bus.mem_address : addr_q;
  assign off     = la - BASE_ADDR;
  assign idx     = off[ADDR_WIDTH+1:2];
  assign hit     = ((la ^ BASE_ADDR) & HI_MASK) == 32'd0;
  assign rd_word = hit ? mem[idx] : 32'd0;
  assign unused  = ^off;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      op_wr   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      resp_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      resp_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= bus.mem_write;
            addr_q  <= bus.mem_address;
            wdata_q <= bus.mem_wdata;
            be_q    <= bus.mem_byte_enable;
            cnt     <= LAT_M1;
            if (LATENCY == 1) begin
              state  <= RESP;
              resp_q <= 1'b1;
              if (!bus.mem_write)
                rdata_q <= rd_word;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state  <= RESP;
            resp_q <= 1'b1;
            if (!op_wr)
              rdata_q <= rd_word;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write commits on the edge closing the RESP cycle; reset wins.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && op_wr && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i])
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_q;

`ifdef MEM_PROTO_CHECK_EN
  localparam logic BASE_BAD = |BASE_ADDR[11:0];

  logic pe_q;
  logic dual;
  logic drop;
  logic diff;

  assign dual = (state == IDLE) & bus.mem_read & bus.mem_write;
  assign drop = op_wr ? !bus.mem_write : !bus.mem_read;
  assign diff = (bus.mem_write != op_wr)
              | (bus.mem_address != addr_q)
              | (bus.mem_wdata != wdata_q)
              | (bus.mem_byte_enable != be_q);

  always_ff @(posedge clk) begin
    if (rst)
      pe_q <= 1'b0;
    else if (BASE_BAD || dual || (state == BUSY && (drop || diff)))
      pe_q <= 1'b1;
  end

  assign bus.proto_err = pe_q;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed + random bench for mem_responder against a
// word-array model of the scratchpad.
module tb_mem_responder;
  localparam int LAT = 2;
  localparam int AW  = 10;
`ifdef MEM_PROTO_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(
    .ADDR_WIDTH(AW),
    .LATENCY(LAT),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [31:0] model [int];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_map(input logic [31:0] a);
    return a < 32'd4096;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mget(input int w);
    return model.exists(w) ? model[w] : 32'd0;
  endfunction

  task automatic idle_bus();
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'h0;
    bus.mem_address     = 32'h0;
    bus.mem_wdata       = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_bus();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
  endtask

  // One request; returns data seen in the resp cycle, latency, resp cycle.
  task automatic xfer(input logic wr, input logic rd_too,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd,
                      output int lat, output int rcyc);
    @(negedge clk);
    bus.mem_read        = !wr | rd_too;
    bus.mem_write       = wr;
    bus.mem_address     = a;
    bus.mem_wdata       = wd;
    bus.mem_byte_enable = be;
    lat  = 0;
    rd   = 32'h0;
    rcyc = -1;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(posedge clk); #1;
      if (bus.mem_resp) begin
        lat  = k;
        rd   = bus.mem_rdata;
        rcyc = cyc;
        break;
      end
    end
    @(negedge clk);
    idle_bus();
    @(posedge clk); #1;
    chk("resp_single", {31'd0, bus.mem_resp}, 32'd0);
  endtask

  task automatic op(input string tag, input logic wr, input logic rd_too,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] be, output int rcyc);
    logic [31:0] rd;
    logic [31:0] exp;
    int lat;
    int w;
    w = int'(a >> 2);
    xfer(wr, rd_too, a, wd, be, rd, lat, rcyc);
    chk({tag, "_lat"}, lat, LAT);
    if (wr) begin
      exp = last_rd;
      if (in_map(a)) model[w] = merge(mget(w), wd, be);
    end else begin
      exp = in_map(a) ? mget(w) : 32'h0;
      last_rd = exp;
    end
    chk({tag, "_data"}, rd, exp);
  endtask

  initial begin
    int rc;
    int r1;
    int r2;
    logic [31:0] a;
    logic [31:0] old20;
    logic [31:0] w1;
    logic wr;

    idle_bus();
    rst = 1'b1;
    last_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp", {31'd0, bus.mem_resp}, 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_perr", {31'd0, bus.proto_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op("pre0", 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rc);
    for (int i = 1; i < 16; i++)
      op("pre", 1'b1, 1'b0, 32'(i * 4), $urandom, 4'hF, rc);

    op("rd0", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rc);
    chk("rd0_zero", last_rd, 32'h0);
    chk("perr0", {31'd0, bus.proto_err}, 32'd0);

    op("wfull", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, rc);
    op("wbyte", 1'b1, 1'b0, 32'h10, 32'h000000AA, 4'h1, rc);
    op("rmrg", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rc);
    chk("merge_const", last_rd, 32'hDEADBEAA);

    op("b2b1", 1'b0, 1'b0, 32'h4, 32'h0, 4'h0, r1);
    op("b2b2", 1'b0, 1'b0, 32'h8, 32'h0, 4'h0, r2);
    chk("b2b_gap", 32'(r2 - r1), 32'd3);

    op("oor_rd", 1'b0, 1'b0, 32'h2000, 32'h0, 4'h0, rc);
    op("oor_wr", 1'b1, 1'b0, 32'h2000, 32'h12345678, 4'hF, rc);
    op("oor_chk", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rc);

    op("be0_wr", 1'b1, 1'b0, 32'hC, 32'hFFFFFFFF, 4'h0, rc);
    op("be0_rd", 1'b0, 1'b0, 32'hC, 32'h0, 4'h0, rc);

    op("both", 1'b1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, rc);
    chk("both_perr", {31'd0, bus.proto_err}, {31'd0, PCHK});
    op("both_rd", 1'b0, 1'b0, 32'h14, 32'h0, 4'h0, rc);
    do_reset();
    chk("perr_clr", {31'd0, bus.proto_err}, 32'd0);

    old20 = mget(8);
    @(negedge clk);
    bus.mem_write       = 1'b1;
    bus.mem_address     = 32'h20;
    bus.mem_wdata       = 32'hA5A5A5A5;
    bus.mem_byte_enable = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_bus();
    @(posedge clk); #1;
    chk("rstb_resp", {31'd0, bus.mem_resp}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rstb_quiet", {31'd0, bus.mem_resp}, 32'd0);
    end
    op("rstb_rd", 1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rc);
    chk("rstb_old", last_rd, old20);

    w1 = mget(1);
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h4;
    @(posedge clk);
    @(negedge clk);
    bus.mem_address = 32'h8;
    @(posedge clk); #1;
    chk("chg_resp", {31'd0, bus.mem_resp}, 32'd1);
    chk("chg_data", bus.mem_rdata, w1);
    chk("chg_perr", {31'd0, bus.proto_err}, {31'd0, PCHK});
    @(negedge clk);
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    chk("chg_hold", {31'd0, bus.proto_err}, {31'd0, PCHK});
    last_rd = w1;
    do_reset();
    chk("chg_clr", {31'd0, bus.proto_err}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom);
      a  = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
      op("rnd", wr, 1'b0, a, $urandom, 4'($urandom), rc);
      chk("rnd_perr", {31'd0, bus.proto_err}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
